// File: rtl/pipeline_stall_ctrl.sv
// Central stall sequencer: merges per-stage stall requests into stop_all,
// runs the multi-cycle EX countdown FSM, the MEM bus-wait watchdog and stall statistics.
module pipeline_stall_ctrl #(
  parameter int STOP_WIDTH  = 6,
  parameter int LEN_WIDTH   = 6,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_stall_req,
  input  logic                  id_stall_req,
  input  logic                  ex_multi_req,
  input  logic [LEN_WIDTH-1:0]  ex_multi_len,
  input  logic                  mem_stall_req,
  input  logic                  flush,
  input  logic                  stat_clear,
  output logic [STOP_WIDTH-1:0] stop_all,
  output logic                  ex_multi_done,
  output logic                  mem_timeout,
  output logic                  ex_busy,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  localparam int WD_WIDTH = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WD_WIDTH-1:0]   WD_LAST   = WD_WIDTH'(MEM_TIMEOUT - 1);
  localparam logic [STOP_WIDTH-1:0] STOP_MEM  = STOP_WIDTH'(6'b011111);
  localparam logic [STOP_WIDTH-1:0] STOP_EX   = STOP_WIDTH'(6'b001111);
  localparam logic [STOP_WIDTH-1:0] STOP_ID   = STOP_WIDTH'(6'b000111);
  localparam logic [STOP_WIDTH-1:0] STOP_IF   = STOP_WIDTH'(6'b000011);
  localparam logic [STOP_WIDTH-1:0] STOP_NONE = STOP_WIDTH'(6'b000000);

  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_BUSY = 2'd1,
    EX_DONE = 2'd2
  } ex_state_t;

  ex_state_t               state_r;
  ex_state_t               state_nxt_s;
  logic [LEN_WIDTH-1:0]    cnt_r;
  logic [LEN_WIDTH-1:0]    cnt_nxt_s;
  logic [WD_WIDTH-1:0]     wd_r;
  logic [WD_WIDTH-1:0]     wd_nxt_s;
  logic [CNT_WIDTH-1:0]    count_r;
  logic                    wd_last_s;
  logic                    mem_eff_s;
  logic                    ex_eff_s;
  logic [STOP_WIDTH-1:0]   stop_s;

  // Watchdog and effective-stall decode; the timeout cycle drops the MEM stall.
  always_comb begin
    wd_last_s = (wd_r == WD_LAST);
    mem_eff_s = mem_stall_req && !wd_last_s;
    ex_eff_s  = ((state_r == EX_IDLE) && ex_multi_req) || (state_r == EX_BUSY);
  end

  // Next-state logic for the EX countdown FSM; a live MEM stall freezes it.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (flush) begin
      state_nxt_s = EX_IDLE;
      cnt_nxt_s   = {LEN_WIDTH{1'b0}};
    end else if (mem_eff_s) begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
    end else begin
      case (state_r)
        EX_IDLE: begin
          if (ex_multi_req) begin
            // Length 0 behaves as length 1: a single stall cycle then done.
            if (ex_multi_len <= LEN_WIDTH'(1)) begin
              state_nxt_s = EX_DONE;
            end else begin
              state_nxt_s = EX_BUSY;
              cnt_nxt_s   = ex_multi_len - LEN_WIDTH'(2);
            end
          end else begin
            state_nxt_s = EX_IDLE;
          end
        end
        EX_BUSY: begin
          if (cnt_r == {LEN_WIDTH{1'b0}}) begin
            state_nxt_s = EX_DONE;
          end else begin
            cnt_nxt_s = cnt_r - LEN_WIDTH'(1);
          end
        end
        EX_DONE: state_nxt_s = EX_IDLE;
        default: begin
          state_nxt_s = EX_IDLE;
          cnt_nxt_s   = {LEN_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // Watchdog counts consecutive MEM wait cycles and restarts after firing.
  always_comb begin
    wd_nxt_s = wd_r;
    if (flush) begin
      wd_nxt_s = {WD_WIDTH{1'b0}};
    end else if (!mem_stall_req || wd_last_s) begin
      wd_nxt_s = {WD_WIDTH{1'b0}};
    end else begin
      wd_nxt_s = wd_r + WD_WIDTH'(1);
    end
  end

  // Priority merge of stall sources into the per-stage stop bus.
  always_comb begin
    stop_s = STOP_NONE;
    if (reset || flush) begin
      stop_s = STOP_NONE;
    end else if (mem_eff_s) begin
      stop_s = STOP_MEM;
    end else if (ex_eff_s) begin
      stop_s = STOP_EX;
    end else if (id_stall_req) begin
      stop_s = STOP_ID;
    end else if (if_stall_req) begin
      stop_s = STOP_IF;
    end else begin
      stop_s = STOP_NONE;
    end
  end

  // Zero-latency status outputs consumed at the same edge as stop_all.
  always_comb begin
    stop_all      = stop_s;
    ex_multi_done = !reset && !flush && !mem_eff_s && (state_r == EX_DONE);
    mem_timeout   = !reset && !flush && mem_stall_req && wd_last_s;
    ex_busy       = !reset && (state_r != EX_IDLE);
    stall_count   = count_r;
  end

  // Sequencer state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= EX_IDLE;
      cnt_r   <= {LEN_WIDTH{1'b0}};
      wd_r    <= {WD_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      wd_r    <= wd_nxt_s;
    end
  end

  // Saturating stall-cycle statistic; flush does not touch it.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= {CNT_WIDTH{1'b0}};
    end else if (stat_clear) begin
      count_r <= {CNT_WIDTH{1'b0}};
    end else if ((stop_s != STOP_NONE) && (count_r != {CNT_WIDTH{1'b1}})) begin
      count_r <= count_r + CNT_WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized and directed bench for pipeline_stall_ctrl against a cycle-count
// reference model (remaining stall cycles, wait-run length, saturating tally).
module tb_pipeline_stall_ctrl;

  localparam int T = 16;
  localparam int CW = 8;

  logic          clock;
  logic          reset;
  logic          if_stall_req;
  logic          id_stall_req;
  logic          ex_multi_req;
  logic [5:0]    ex_multi_len;
  logic          mem_stall_req;
  logic          flush;
  logic          stat_clear;
  logic [5:0]    stop_all;
  logic          ex_multi_done;
  logic          mem_timeout;
  logic          ex_busy;
  logic [CW-1:0] stall_count;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Reference model state
  int m_rem = 0;        // EX stall cycles still owed by the current op
  bit m_done_pend = 0;  // op finished, done pulse owed
  int m_wait = 0;       // consecutive MEM wait cycles since last clear
  int m_count = 0;      // expected stall_count

  pipeline_stall_ctrl #(
    .STOP_WIDTH(6), .LEN_WIDTH(6), .MEM_TIMEOUT(T), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
    .ex_multi_req(ex_multi_req), .ex_multi_len(ex_multi_len),
    .mem_stall_req(mem_stall_req), .flush(flush), .stat_clear(stat_clear),
    .stop_all(stop_all), .ex_multi_done(ex_multi_done),
    .mem_timeout(mem_timeout), .ex_busy(ex_busy), .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit r, input bit i_if, input bit i_id, input bit i_ex,
                       input logic [5:0] len, input bit mem, input bit fl, input bit clr);
    bit to, meff, exs, e_done, e_busy;
    logic [5:0] e_stop;
    int l;
    @(negedge clock);
    reset = r; if_stall_req = i_if; id_stall_req = i_id; ex_multi_req = i_ex;
    ex_multi_len = len; mem_stall_req = mem; flush = fl; stat_clear = clr;
    #1;
    to     = mem && (m_wait == T - 1);
    meff   = mem && !to;
    exs    = m_done_pend ? 1'b0 : ((m_rem > 0) ? 1'b1 : i_ex);
    e_done = m_done_pend && !meff;
    e_busy = (m_rem > 0) || m_done_pend;
    if (meff)      e_stop = 6'b011111;
    else if (exs)  e_stop = 6'b001111;
    else if (i_id) e_stop = 6'b000111;
    else if (i_if) e_stop = 6'b000011;
    else           e_stop = 6'b000000;
    if (fl) begin
      e_stop = 6'd0; e_done = 1'b0; to = 1'b0;
    end
    if (r) begin
      e_stop = 6'd0; e_done = 1'b0; to = 1'b0; e_busy = 1'b0;
    end
    check_eq("stop_all", 32'(stop_all), 32'(e_stop));
    check_eq("ex_multi_done", 32'(ex_multi_done), 32'(e_done));
    check_eq("mem_timeout", 32'(mem_timeout), 32'(to));
    check_eq("ex_busy", 32'(ex_busy), 32'(e_busy));
    check_eq("stall_count", 32'(stall_count), 32'(m_count));
    if (r) begin
      m_rem = 0; m_done_pend = 0; m_wait = 0; m_count = 0;
    end else begin
      if (clr) m_count = 0;
      else if (e_stop != 6'd0 && m_count < (1 << CW) - 1) m_count++;
      if (fl) begin
        m_rem = 0; m_done_pend = 0; m_wait = 0;
      end else begin
        m_wait = (mem && !to) ? m_wait + 1 : 0;
        if (!meff) begin
          if (m_done_pend) m_done_pend = 0;
          else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_done_pend = 1;
          end else if (i_ex) begin
            l = (len == 6'd0) ? 1 : int'(len);
            m_rem = l - 1;
            if (m_rem == 0) m_done_pend = 1;
          end
        end
      end
    end
  endtask

  int burst = 0;
  bit rm;

  initial begin
    reset = 1'b1; if_stall_req = 1'b1; id_stall_req = 1'b1; ex_multi_req = 1'b1;
    ex_multi_len = 6'd5; mem_stall_req = 1'b1; flush = 1'b0; stat_clear = 1'b0;
    @(posedge clock);
    // Reset with every request high, then quiet release
    repeat (2) cycle(1, 1, 1, 1, 6'd5, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 6'd0, 0, 0, 0);
    // len=3 op, then len=3 op with MEM wait in cycles 1-2
    repeat (4) cycle(0, 0, 0, 1, 6'd3, 0, 0, 0);
    cycle(0, 0, 0, 0, 6'd0, 0, 0, 0);
    cycle(0, 0, 0, 1, 6'd3, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 1, 6'd3, 1, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 6'd0, 0, 0, 0);
    // MEM held past the watchdog
    repeat (20) cycle(0, 0, 0, 0, 6'd0, 1, 0, 0);
    cycle(0, 0, 0, 0, 6'd0, 0, 0, 0);
    // ID+IF together, then flush while BUSY
    repeat (2) cycle(0, 1, 1, 0, 6'd0, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 1, 6'd5, 0, 0, 0);
    cycle(0, 0, 0, 1, 6'd5, 0, 1, 0);
    repeat (3) cycle(0, 0, 0, 0, 6'd0, 0, 0, 0);
    // Length 0 and 1 ops
    cycle(0, 0, 0, 1, 6'd0, 0, 0, 0);
    cycle(0, 0, 0, 0, 6'd0, 0, 0, 0);
    cycle(0, 0, 0, 1, 6'd1, 0, 0, 0);
    cycle(0, 0, 0, 0, 6'd0, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 24);
      rm = (burst > 0);
      if (burst > 0) burst--;
      cycle(0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0,
            ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7)),
            rm, $urandom_range(0, 29) == 0, $urandom_range(0, 49) == 0);
    end
    // Counter saturation and clear-with-stall
    cycle(0, 0, 1, 0, 6'd0, 0, 0, 1);
    repeat (300) cycle(0, 0, 1, 0, 6'd0, 0, 0, 0);
    check_eq("sat_count", 32'(stall_count), 32'd255);
    cycle(0, 0, 1, 0, 6'd0, 0, 0, 1);
    cycle(0, 0, 0, 0, 6'd0, 0, 0, 0);
    check_eq("clear_count", 32'(stall_count), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
